dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequencer and arbiter in front of the single-port data RAM core (32-bit words, synchronous read, 1-cycle read latency).
- Shares the RAM between two requesters: port 0 is the CPU load/store unit; port 1 is the boot loader / debug path.
- Performs byte and halfword stores as explicit read-modify-write sequences, and formats load data by rw_type.
- Checks alignment and address range before any RAM access.

Parameters:
- ADDR_W, 32, requester byte-address width.
- RAM_AW, 13, RAM word-address width; the RAM holds 2^RAM_AW words.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  2  per-port request valid; bit i belongs to port i.
- req_ready  out  2  per-port accept; one-hot or zero.
- req_we  in  2  per-port write flag.
- req_addr0, req_addr1  in  ADDR_W  byte address.
- req_type0, req_type1  in  3  rw_type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_wdata0, req_wdata1  in  32  store data, right-aligned.
- rsp_valid  out  2  one-cycle response pulse to the owning port.
- rsp_rdata  out  32  load result, shared by both ports.
- rsp_err  out  1  error flag, qualified by rsp_valid.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_AW  RAM word address.
- ram_wdata  out  32  RAM write word.
- ram_rdata  in  32  RAM read word, valid the cycle after ram_en=1 with ram_we=0.

Behaviour:
- Reset values: state=IDLE; req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0; last_grant=1, so port 0 wins first.
- Async reset mid-sequence: abort immediately, drop ram_we the same instant, issue no response. A partially completed RMW leaves the RAM word untouched, because the write only happens in WR.
- Arbitration (IDLE only):
  - A single requester is granted.
  - If both request, round-robin: grant the port not equal to last_grant, then update last_grant.
  - req_ready[g] is combinational = (state==IDLE) & req_valid[g].
  - On accept, latch we, addr, type and wdata into command registers and record owner=g.
  - Outside IDLE, req_ready=0.
- Checks, done at accept:
  - type 011, 110 or 111 → error.
  - 110 or 111 with we=1 → also error.
  - H/HU with addr[0]=1 → error; W with addr[1:0]≠0 → error.
  - addr[ADDR_W-1:RAM_AW+2] ≠ 0 → error.
  - On any error: go IDLE→RSP, no RAM access, rsp_err=1, rsp_rdata=0.
- States:
  - IDLE: accepts per the arbitration rule above.
  - RD: ram_en=1, ram_we=0, ram_addr=cmd_addr[RAM_AW+1:2].
  - RD_DATA: register ram_rdata into the hold register.
  - WR: ram_en=1, ram_we=1, ram_wdata = merged word.
  - RSP: rsp_valid[owner]=1 for exactly one cycle, then IDLE.
- Transitions:
  - Load: IDLE→RD→RD_DATA→RSP.
  - Word store: IDLE→WR→RSP.
  - B/H store: IDLE→RD→RD_DATA→WR→RSP.
- Latency, with accept at cycle T: load rsp_valid at T+3; word store at T+2; sub-word store at T+4; error at T+1.
- Throughput: the next accept can occur in the cycle after RSP.
- Load formatting:
  - B/BU select byte addr[1:0]; H/HU select halfword addr[1].
  - B and H sign-extend; BU and HU zero-extend.
  - W passes the word through.
  - rsp_rdata holds its value until the next response.
- Store merge: replace only the addressed lane(s) of the hold word with wdata[7:0] or wdata[15:0]; all other bytes are preserved.
- Responses: no backpressure, so requesters must sample on the rsp_valid pulse. A requester may keep req_valid asserted for its next command. rsp_valid is never asserted to both ports in one cycle.
- Signals driven combinationally from state and command registers: ram_* outputs. All rsp_* outputs are registered.

Decomposition:
- Shared package dmem_pkg:
  - rw_type constants RW_B, RW_H, RW_W, RW_BU, RW_HU.
  - State encoding IDLE, RD, RD_DATA, WR, RSP.
- One combinational sub-module, dmem_lane_fmt, with inputs word, addr[1:0], type, wdata and outputs load_data, merged_word. The same unit is reused later by the instruction-side loader.

Test Plan:
- Port0 W store 0xDEADBEEF @0x10, then W load @0x10 → ram_we pulse at T+1 with addr=4; rsp_rdata=0xDEADBEEF with rsp_valid[0] at T+3.
- Word @0x20=0x11223344; port0 B store 0xAA @0x22 → word becomes 0x11AA3344; LB @0x22 → 0xFFFFFFAA; LBU @0x22 → 0x000000AA.
- H store 0x8001 @0x26 onto 0x00000000 → word 0x80010000; LH @0x26 → 0xFFFF8001; LHU → 0x00008001.
- Both ports hold req_valid continuously for 4 requests each → grants alternate 0,1,0,1…, with exactly one rsp_valid bit per response.
- LW @0x13, SH @0x21, type 111, addr above the RAM range → rsp_err=1 at T+1; ram_en never asserted.
- Assert rst during WR of a sub-word store → ram_we drops immediately, no rsp_valid; after reset release, a read of the target word returns the old value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared rw_type codes, sequencer states and access-legality helper for the data memory path.
// Used by dmem_arbiter and dmem_lane_fmt; no logic of its own.
package dmem_pkg;

    localparam logic [2:0] RW_B  = 3'b000;
    localparam logic [2:0] RW_H  = 3'b001;
    localparam logic [2:0] RW_W  = 3'b010;
    localparam logic [2:0] RW_BU = 3'b100;
    localparam logic [2:0] RW_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_DATA,
        WR,
        RSP
    } state_t;

    // Undefined rw_type codes are illegal for loads and stores alike.
    function automatic logic rw_bad(input logic [2:0] rw_type, input logic [1:0] addr_lo);
        case (rw_type)
            RW_B, RW_BU: rw_bad = 1'b0;
            RW_H, RW_HU: rw_bad = addr_lo[0];
            RW_W:        rw_bad = (addr_lo != 2'b00);
            default:     rw_bad = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte/halfword lane formatter: extracts and extends load data, merges store data into a word.
// Purely combinational, zero latency; no flow control.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  rw_type,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? word[31:16] : word[15:0];

        case (rw_type)
            RW_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            RW_BU:   load_data = {24'h000000, byte_sel};
            RW_H:    load_data = {{16{half_sel[15]}}, half_sel};
            RW_HU:   load_data = {16'h0000, half_sel};
            default: load_data = word;
        endcase

        merged_word = word;
        case (rw_type)
            RW_B, RW_BU: merged_word[{addr, 3'b000} +: 8] = wdata[7:0];
            RW_H, RW_HU: begin
                if (addr[1]) merged_word[31:16] = wdata[15:0];
                else         merged_word[15:0]  = wdata[15:0];
            end
            default:     merged_word = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin sequencer for the single-port data RAM; sub-word stores run as read-modify-write.
// Latency from accept: load 3, word store 2, sub-word store 4, error 1; one command in flight, responses unthrottled.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RAM_AW = 13
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_we,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [2:0]        req_type0,
    input  logic [2:0]        req_type1,
    input  logic [31:0]       req_wdata0,
    input  logic [31:0]       req_wdata1,
    output logic [1:0]        rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_t state, state_nxt;

    logic              grant, accept, owner, last_grant, rsp_owner;
    logic              sel_we, sel_err;
    logic [ADDR_W-1:0] sel_addr;
    logic [2:0]        sel_type;
    logic [31:0]       sel_wdata;

    logic              cmd_we;
    logic [RAM_AW+1:0] cmd_addr;
    logic [2:0]        cmd_type;
    logic [31:0]       cmd_wdata, hold, fmt_word, load_data, merged_word;

    always_comb begin
        grant     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        accept    = (state == IDLE) && (req_valid != 2'b00);
        req_ready = 2'b00;
        if (accept) req_ready[grant] = 1'b1;

        sel_we    = req_we[grant];
        sel_addr  = grant ? req_addr1  : req_addr0;
        sel_type  = grant ? req_type1  : req_type0;
        sel_wdata = grant ? req_wdata1 : req_wdata0;
        sel_err   = rw_bad(sel_type, sel_addr[1:0]) || ((sel_addr >> (RAM_AW + 2)) != '0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sel_err)                      state_nxt = RSP;
                    else if (sel_we && sel_type == RW_W) state_nxt = WR;
                    else                              state_nxt = RD;
                end
            end
            RD:      state_nxt = RD_DATA;
            RD_DATA: state_nxt = cmd_we ? WR : RSP;
            WR:      state_nxt = RSP;
            RSP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM strobes follow state directly so an async reset kills a write in the same instant.
    always_comb begin
        ram_en    = (state == RD) || (state == WR);
        ram_we    = (state == WR);
        ram_addr  = ram_en ? cmd_addr[RAM_AW+1:2] : '0;
        ram_wdata = ram_we ? merged_word : '0;
        fmt_word  = (state == RD_DATA) ? ram_rdata : hold;
        rsp_owner = (state == IDLE) ? grant : owner;
    end

    dmem_lane_fmt u_lane_fmt (
        .word        (fmt_word),
        .addr        (cmd_addr[1:0]),
        .rw_type     (cmd_type),
        .wdata       (cmd_wdata),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_type   <= RW_W;
            cmd_wdata  <= '0;
            hold       <= '0;
            rsp_valid  <= 2'b00;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cmd_we     <= sel_we;
                cmd_addr   <= sel_addr[RAM_AW+1:0];
                cmd_type   <= sel_type;
                cmd_wdata  <= sel_wdata;
                owner      <= grant;
                last_grant <= grant;
            end
            if (state == RD_DATA) hold <= ram_rdata;

            rsp_valid <= 2'b00;
            if (state_nxt == RSP) begin
                rsp_valid[rsp_owner] <= 1'b1;
                rsp_err              <= (state == IDLE);
                rsp_rdata            <= (state == RD_DATA && !cmd_we) ? load_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized check of dmem_arbiter against a word-array memory model and latency rules.
module tb_dmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int RAM_AW = 13;
    localparam int NWORDS = 1 << RAM_AW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req_valid = 2'b00;
    logic [1:0]        req_ready;
    logic [1:0]        req_we = 2'b00;
    logic [ADDR_W-1:0] req_addr0 = '0, req_addr1 = '0;
    logic [2:0]        req_type0 = 3'b010, req_type1 = 3'b010;
    logic [31:0]       req_wdata0 = '0, req_wdata1 = '0;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              ram_en, ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .RAM_AW(RAM_AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_type0(req_type0), .req_type1(req_type1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Environment RAM: synchronous, one-cycle read latency.
    logic [31:0] ram_mem [NWORDS];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  rwt;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t        q0[$], q1[$];
    logic [31:0] ref_mem [NWORDS];
    int          tests = 0, fails = 0, cyc = 0;
    bit          outstanding = 0, exp_err = 0, exp_chk_data = 0;
    int          rsp_at = 0, wr_at = -1, exp_port = 0, idle_from = 0, m_last = 1;
    logic [31:0] exp_rdata = '0, last_rd = '0;
    logic [12:0] exp_waddr = '0;
    bit          last_err = 0;
    int          grant_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference semantics: plain arithmetic on a word array.
    task automatic model_access(input cmd_t c, output int lat, output bit err, output logic [31:0] rd);
        logic [31:0] w, b, h;
        int idx, sh;
        err = (c.rwt == 3) || (c.rwt == 6) || (c.rwt == 7)
           || ((c.rwt == 1 || c.rwt == 5) && c.addr[0])
           || (c.rwt == 2 && c.addr[1:0] != 2'b00)
           || (c.addr >= (32'd1 << (RAM_AW + 2)));
        rd  = '0;
        lat = 1;
        if (!err) begin
            idx = int'(c.addr[RAM_AW+1:2]);
            w   = ref_mem[idx];
            b   = (w >> (8 * int'(c.addr[1:0]))) & 32'hFF;
            h   = (w >> (16 * int'(c.addr[1]))) & 32'hFFFF;
            if (!c.we) begin
                lat = 3;
                case (c.rwt)
                    3'd0:    rd = b[7] ? (b | 32'hFFFFFF00) : b;
                    3'd4:    rd = b;
                    3'd1:    rd = h[15] ? (h | 32'hFFFF0000) : h;
                    3'd5:    rd = h;
                    default: rd = w;
                endcase
            end else if (c.rwt == 2) begin
                lat = 2;
                ref_mem[idx] = c.wdata;
            end else if (c.rwt == 0) begin
                lat = 4;
                sh  = 8 * int'(c.addr[1:0]);
                ref_mem[idx] = (w & ~(32'hFF << sh)) | ((c.wdata & 32'hFF) << sh);
            end else begin
                lat = 4;
                sh  = 16 * int'(c.addr[1]);
                ref_mem[idx] = (w & ~(32'hFFFF << sh)) | ((c.wdata & 32'hFFFF) << sh);
            end
        end
    endtask

    task automatic step(input bit gaps);
        logic [1:0] v, exp_rdy;
        int g, lat;
        bit err;
        logic [31:0] rd;
        cmd_t c;
        @(negedge clk);
        cyc++;
        if (outstanding && cyc == rsp_at) begin
            chk("rsp_valid", 32'(rsp_valid), exp_port ? 32'd2 : 32'd1);
            chk("rsp_err", 32'(rsp_err), 32'(exp_err));
            if (exp_chk_data) chk("rsp_rdata", rsp_rdata, exp_rdata);
            last_rd     = rsp_rdata;
            last_err    = rsp_err;
            outstanding = 0;
            idle_from   = cyc + 1;
        end else begin
            chk("rsp_quiet", 32'(rsp_valid), 32'd0);
        end
        if (outstanding) begin
            if (exp_err) chk("err_no_ram", 32'(ram_en), 32'd0);
            else if (cyc == wr_at) begin
                chk("ram_we_pulse", 32'(ram_we), 32'd1);
                chk("ram_addr", 32'(ram_addr), 32'(exp_waddr));
            end else chk("ram_we_low", 32'(ram_we), 32'd0);
        end

        v[0] = (q0.size() > 0) && (!gaps || $urandom_range(3) != 0);
        v[1] = (q1.size() > 0) && (!gaps || $urandom_range(3) != 0);
        req_valid = v;
        if (q0.size() > 0) begin
            req_we[0] = q0[0].we; req_addr0 = q0[0].addr; req_type0 = q0[0].rwt; req_wdata0 = q0[0].wdata;
        end
        if (q1.size() > 0) begin
            req_we[1] = q1[0].we; req_addr1 = q1[0].addr; req_type1 = q1[0].rwt; req_wdata1 = q1[0].wdata;
        end
        #1;
        exp_rdy = 2'b00;
        g = 0;
        if (!outstanding && cyc >= idle_from && v != 2'b00) begin
            g = (v == 2'b11) ? 1 - m_last : (v[1] ? 1 : 0);
            exp_rdy = (g == 1) ? 2'b10 : 2'b01;
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (exp_rdy != 2'b00) begin
            c = (g == 1) ? q1.pop_front() : q0.pop_front();
            model_access(c, lat, err, rd);
            outstanding  = 1;
            rsp_at       = cyc + lat;
            exp_port     = g;
            exp_err      = err;
            exp_rdata    = rd;
            exp_chk_data = err || !c.we;
            wr_at        = (c.we && !err) ? cyc + lat - 1 : -1;
            exp_waddr    = c.addr[14:2];
            m_last       = g;
            grant_log.push_back(g);
        end
    endtask

    task automatic drain(input bit gaps);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || outstanding) && n < 2000) begin
            step(gaps);
            n++;
        end
        tests++;
        assert (n < 2000) else begin
            fails++;
            $error("FAIL drain_timeout: got %0d cycles expected under 2000", n);
        end
        req_valid = 2'b00;
    endtask

    task automatic run1(input int p, input bit we, input logic [31:0] addr,
                        input logic [2:0] rwt, input logic [31:0] wdata);
        cmd_t c;
        c.we = we; c.addr = addr; c.rwt = rwt; c.wdata = wdata;
        if (p == 1) q1.push_back(c); else q0.push_back(c);
        drain(0);
    endtask

    task automatic model_reset();
        outstanding = 0;
        m_last      = 1;
        idle_from   = 0;
    endtask

    initial begin
        cmd_t c;
        for (int i = 0; i < NWORDS; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        rst = 1'b0;
        model_reset();

        // Word store then load
        run1(0, 1, 32'h10, 3'b010, 32'hDEADBEEF);
        run1(0, 0, 32'h10, 3'b010, 32'h0);
        chk("lw_0x10", last_rd, 32'hDEADBEEF);

        // Byte store RMW and signed/unsigned byte loads
        run1(0, 1, 32'h20, 3'b010, 32'h11223344);
        run1(0, 1, 32'h22, 3'b000, 32'h123456AA);
        run1(0, 0, 32'h20, 3'b010, 32'h0);
        chk("sb_merge", last_rd, 32'h11AA3344);
        run1(0, 0, 32'h22, 3'b000, 32'h0);
        chk("lb_0x22", last_rd, 32'hFFFFFFAA);
        run1(1, 0, 32'h22, 3'b100, 32'h0);
        chk("lbu_0x22", last_rd, 32'h000000AA);

        // Halfword store RMW and halfword loads
        run1(0, 1, 32'h26, 3'b001, 32'hFFFF8001);
        run1(0, 0, 32'h24, 3'b010, 32'h0);
        chk("sh_merge", last_rd, 32'h80010000);
        run1(0, 0, 32'h26, 3'b001, 32'h0);
        chk("lh_0x26", last_rd, 32'hFFFF8001);
        run1(1, 0, 32'h26, 3'b101, 32'h0);
        chk("lhu_0x26", last_rd, 32'h00008001);

        // Error cases
        run1(0, 0, 32'h13, 3'b010, 32'h0);
        chk("lw_misaligned_err", 32'(last_err), 32'd1);
        run1(0, 1, 32'h21, 3'b001, 32'h5555);
        chk("sh_misaligned_err", 32'(last_err), 32'd1);
        run1(1, 0, 32'h20, 3'b111, 32'h0);
        chk("type111_err", 32'(last_err), 32'd1);
        run1(0, 1, 32'h20, 3'b110, 32'h1);
        chk("type110_store_err", 32'(last_err), 32'd1);
        run1(0, 0, 32'h8000, 3'b010, 32'h0);
        chk("range_err", 32'(last_err), 32'd1);
        chk("range_err_rdata", last_rd, 32'd0);
        run1(0, 0, 32'h24, 3'b010, 32'h0);
        chk("no_err_after", 32'(last_err), 32'd0);

        // Round-robin with both ports held valid, fresh from reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            c.we = 0; c.rwt = 3'b010; c.wdata = '0;
            c.addr = 32'h10; q0.push_back(c);
            c.addr = 32'h20; q1.push_back(c);
        end
        drain(0);
        chk("rr_count", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < grant_log.size(); i++) chk("rr_order", 32'(grant_log[i]), 32'(i % 2));

        // Reset during the WR cycle of a byte store
        run1(0, 1, 32'h40, 3'b010, 32'hCAFEF00D);
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b01; req_addr0 = 32'h41; req_type0 = 3'b000; req_wdata0 = 32'h55;
        #1;
        chk("abort_accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_wr", 32'(ram_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_we_drop", 32'(ram_we), 32'd0);
        chk("abort_en_drop", 32'(ram_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        rst = 1'b0;
        model_reset();
        run1(1, 0, 32'h40, 3'b010, 32'h0);
        chk("abort_word_kept", last_rd, 32'hCAFEF00D);

        // Randomized mixed traffic on both ports
        for (int i = 0; i < 80; i++) begin
            c.we    = $urandom_range(1);
            c.addr  = ($urandom_range(7) == 0) ? (32'h8000 + $urandom_range(255)) : $urandom_range(31);
            c.wdata = $urandom;
            if (c.we) begin
                case ($urandom_range(5))
                    0: c.rwt = 3'b000;
                    1: c.rwt = 3'b001;
                    2: c.rwt = 3'b010;
                    3: c.rwt = 3'b011;
                    4: c.rwt = 3'b110;
                    default: c.rwt = 3'b111;
                endcase
            end else begin
                c.rwt = 3'($urandom_range(7));
            end
            if ($urandom_range(1) == 1) q1.push_back(c); else q0.push_back(c);
        end
        drain(1);
        for (int i = 0; i < 8; i++) begin
            run1(i % 2, 0, 32'(i * 4), 3'b010, 32'h0);
            chk("rand_final_word", last_rd, ref_mem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
